conv_encoder_k3: RTL



---
 rtl/conv_enc_pkg.sv | 21 ++
 rtl/conv_enc_branch.sv | 14 +
 rtl/conv_encoder_k3.sv | 136 +++++++++++++
 3 files changed

// File: rtl/conv_enc_pkg.sv
// conv_enc_pkg: shared constants, state enum and symbol bundle for the
// K=3 rate-1/2 convolutional encoder (generators G0=111, G1=101).
package conv_enc_pkg;

    localparam int K = 3;
    localparam logic [K-1:0] G0_DEF = 3'b111;
    localparam logic [K-1:0] G1_DEF = 3'b101;
    localparam int TAIL_LEN = K - 1;
    localparam int CNT_W = $clog2(TAIL_LEN + 1);

    typedef enum logic {
        RUN,
        TAIL
    } enc_state_e;

    typedef struct packed {
        logic [1:0] sym;
        logic       last;
    } enc_sym_t;

endpackage

// File: rtl/conv_enc_branch.sv
// conv_enc_branch: one code branch, parity of (window & G).
// Ports: window [K-1:0] in ({u, sr[1], sr[0]}), parity out.
module conv_enc_branch
    import conv_enc_pkg::*;
#(
    parameter logic [K-1:0] G = G0_DEF
) (
    input  logic [K-1:0] window,
    output logic         parity
);

    assign parity = ^(window & G);

endmodule

// File: rtl/conv_encoder_k3.sv
// conv_encoder_k3: rate-1/2 K=3 encoder, framed bit in, 2-bit symbol out.
// Ports: clk, reset (sync, active-high); in_bit/in_valid/in_last/in_ready;
//   out_sym {c0,c1}/out_valid/out_last/out_ready.
// Build option: CONV_ENC_TAIL_EN appends K-1 zero tail symbols per frame;
//   without it, the last data symbol carries out_last and sr clears.
module conv_encoder_k3
    import conv_enc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [1:0] out_sym,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready
);

    logic [K-2:0] sr_q;
    logic [K-2:0] sr_d;
    logic         slot_free;
    logic         accept;
    logic         load;
    logic         u;
    logic         sym_last;
    logic         c0;
    logic         c1;
    logic [K-1:0] window;
    enc_sym_t     out_q;
    logic         out_valid_q;

    // Output slot can take a new symbol when empty or being drained now.
    assign slot_free = !out_valid_q || out_ready;

`ifdef CONV_ENC_TAIL_EN
    enc_state_e       state_q;
    enc_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign in_ready = (state_q == RUN) && slot_free;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        u        = 1'b0;
        sym_last = 1'b0;
        sr_d     = sr_q;
        unique case (1'b1)
            accept: begin
                load = 1'b1;
                u    = in_bit;
                sr_d = {in_bit, sr_q[1]};
                if (in_last) begin
                    state_d = TAIL;
                    cnt_d   = CNT_W'(TAIL_LEN);
                end
            end
            (state_q == TAIL) && slot_free: begin
                load  = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                sr_d  = {1'b0, sr_q[1]};
                // Final tail bit: trellis is back in state 0.
                if (cnt_q == CNT_W'(1)) begin
                    sym_last = 1'b1;
                    sr_d     = '0;
                    state_d  = RUN;
                end
            end
            default: ;
        endcase
    end
`else
    assign in_ready = slot_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        load     = accept;
        u        = in_bit;
        sym_last = in_last;
        sr_d     = sr_q;
        if (accept) begin
            sr_d = in_last ? '0 : {in_bit, sr_q[1]};
        end
    end
`endif

    assign window = {u, sr_q};

    conv_enc_branch #(.G(G0_DEF)) u_br0 (
        .window (window),
        .parity (c0)
    );

    conv_enc_branch #(.G(G1_DEF)) u_br1 (
        .window (window),
        .parity (c1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q        <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            sr_q <= sr_d;
            if (load) begin
                out_valid_q <= 1'b1;
                out_q.sym   <= {c0, c1};
                out_q.last  <= sym_last;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
                out_q.last  <= 1'b0;
            end
        end
    end

    assign out_sym   = out_q.sym;
    assign out_last  = out_q.last;
    assign out_valid = out_valid_q;

endmodule
